// File: rtl/mini_shader_if.sv
// Instruction/result bundle between the shader sequencer (master) and the ALU core (slave).
interface mini_shader_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned AW     = 3
);
    localparam int unsigned INSTR_W = 16;

    logic [INSTR_W-1:0] instr;
    logic [DATA_W-1:0]  alu_result;
    logic               wb_en;
    logic [AW-1:0]      wb_addr;

    modport master (output instr, input alu_result, wb_en, wb_addr);
    modport slave  (input instr, output alu_result, wb_en, wb_addr);
endinterface

// File: rtl/mini_shader_core.sv
// Single-cycle register-to-register ALU core: decode, execute, write back on the next edge.
module mini_shader_rf #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREGS  = 8,
    parameter int unsigned AW     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr1,
    input  logic [AW-1:0]     raddr2,
    output logic [DATA_W-1:0] rdata1_c,
    output logic [DATA_W-1:0] rdata2_c
);
    logic [DATA_W-1:0] regs [0:NREGS-1];

    // Reset is asynchronous and also blocks any write while held low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1_c = regs[raddr1];
    assign rdata2_c = regs[raddr2];
endmodule

module mini_shader_core #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREGS  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    mini_shader_if.slave  bus
);
    localparam int unsigned AW = $clog2(NREGS);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_MUL = 3'b101,
        OP_SHL = 3'b110,
        OP_NOP = 3'b111
    } opcode_e;

    opcode_e           opcode;
    logic [AW-1:0]     rs1;
    logic [AW-1:0]     rs2;
    logic [AW-1:0]     rd;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu;
    logic              wr_en;

    assign opcode = opcode_e'(bus.instr[15:13]);
    assign rs1    = bus.instr[12:10];
    assign rs2    = bus.instr[9:7];
    assign rd     = bus.instr[6:4];
    assign wr_en  = (opcode != OP_NOP);

    mini_shader_rf #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .AW     (AW)
    ) rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (wr_en),
        .waddr    (rd),
        .wdata    (alu),
        .raddr1   (rs1),
        .raddr2   (rs2),
        .rdata1_c (op_a),
        .rdata2_c (op_b)
    );

    // Results are truncated to DATA_W; carry and product high bits are dropped.
    always_comb begin
        alu = '0;
        unique case (opcode)
            OP_ADD: alu = op_a + op_b;
            OP_SUB: alu = op_a - op_b;
            OP_AND: alu = op_a & op_b;
            OP_OR:  alu = op_a | op_b;
            OP_XOR: alu = op_a ^ op_b;
            OP_MUL: alu = op_a * op_b;
            OP_SHL: alu = op_a << op_b[3:0];
            OP_NOP: alu = '0;
        endcase
    end

    assign bus.alu_result = alu;
    assign bus.wb_en      = wr_en;
    assign bus.wb_addr    = rd;
endmodule

// File: tb/tb_mini_shader_core.sv
// Directed bench for mini_shader_core: write-back results are queued at issue and checked one edge later.
module tb_mini_shader_core;
    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
    localparam logic [2:0] XOR_ = 3'b100, MUL = 3'b101, SHL = 3'b110, NOP = 3'b111;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    typedef struct {
        string       tag;
        int unsigned addr;
        logic [15:0] val;
    } exp_t;
    exp_t sbq[$];

    mini_shader_if bus ();

    mini_shader_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] s1,
                                       input logic [2:0] s2, input logic [2:0] d);
        return {op, s1, s2, d, 4'b0001};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input int unsigned addr, input logic [15:0] val);
        exp_t e;
        e.tag  = tag;
        e.addr = addr;
        e.val  = val;
        sbq.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sbq.size() == 0) begin
            check("sb_underflow", 32'd0, 32'd1);
        end else begin
            e = sbq.pop_front();
            check(e.tag, 32'(dut.rf.regs[e.addr]), 32'(e.val));
        end
    endtask

    // Issue one instruction at the falling edge, check decode outputs, then its write-back.
    task automatic exec(input string tag, input logic [2:0] op, input logic [2:0] s1,
                        input logic [2:0] s2, input logic [2:0] d, input logic [15:0] exp);
        @(negedge clk);
        bus.instr = mk(op, s1, s2, d);
        #1;
        check({tag, "_alu"}, 32'(bus.alu_result), 32'(exp));
        check({tag, "_wben"}, 32'(bus.wb_en), 32'd1);
        check({tag, "_wbaddr"}, 32'(bus.wb_addr), 32'(d));
        push({tag, "_wb"}, 32'(d), exp);
        @(posedge clk);
        #1;
        pop_check();
        @(negedge clk);
        bus.instr = mk(NOP, 3'd0, 3'd0, 3'd0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        bus.instr = mk(NOP, 3'd0, 3'd0, 3'd0);

        // Reset state
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) check($sformatf("reset_r%0d", i), 32'(dut.rf.regs[i]), 32'd0);
        check("reset_nop_wben", 32'(bus.wb_en), 32'd0);
        check("reset_nop_alu", 32'(bus.alu_result), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        dut.rf.regs[0] = 16'd4;
        dut.rf.regs[1] = 16'd3;

        // Basic ops on 4 and 3
        exec("add", ADD, 3'd0, 3'd1, 3'd2, 16'd7);
        exec("sub", SUB, 3'd0, 3'd1, 3'd3, 16'd1);
        exec("and", AND_, 3'd0, 3'd1, 3'd4, 16'd0);
        exec("or", OR_, 3'd0, 3'd1, 3'd5, 16'd7);
        exec("xor", XOR_, 3'd0, 3'd1, 3'd6, 16'd7);
        exec("mul", MUL, 3'd0, 3'd1, 3'd7, 16'd12);
        check("src_r0_kept", 32'(dut.rf.regs[0]), 32'd4);
        check("src_r1_kept", 32'(dut.rf.regs[1]), 32'd3);
        exec("shl", SHL, 3'd0, 3'd1, 3'd2, 16'h0020);

        // NOP leaves destination untouched
        @(negedge clk);
        bus.instr = mk(NOP, 3'd0, 3'd1, 3'd2);
        #1;
        check("nop_wben", 32'(bus.wb_en), 32'd0);
        check("nop_alu", 32'(bus.alu_result), 32'd0);
        check("nop_wbaddr", 32'(bus.wb_addr), 32'd2);
        @(posedge clk);
        #1;
        check("nop_r2_kept", 32'(dut.rf.regs[2]), 32'h0020);

        // Wrap-around boundaries
        @(negedge clk);
        dut.rf.regs[0] = 16'd0;
        dut.rf.regs[1] = 16'd1;
        exec("sub_wrap", SUB, 3'd0, 3'd1, 3'd2, 16'hFFFF);
        dut.rf.regs[0] = 16'h8000;
        dut.rf.regs[1] = 16'd2;
        exec("mul_wrap", MUL, 3'd0, 3'd1, 3'd3, 16'h0000);
        dut.rf.regs[0] = 16'h8001;
        dut.rf.regs[1] = 16'h0011;
        exec("shl_low4", SHL, 3'd0, 3'd1, 3'd4, 16'h0002);
        dut.rf.regs[0] = 16'hFFFF;
        dut.rf.regs[1] = 16'h0002;
        exec("add_wrap", ADD, 3'd0, 3'd1, 3'd5, 16'h0001);

        // rd == rs1 held for two edges
        dut.rf.regs[0] = 16'd4;
        dut.rf.regs[1] = 16'd3;
        @(negedge clk);
        bus.instr = mk(ADD, 3'd0, 3'd1, 3'd0);
        push("hazard_e1", 0, 16'd7);
        @(posedge clk);
        #1;
        pop_check();
        push("hazard_e2", 0, 16'd10);
        @(posedge clk);
        #1;
        pop_check();
        @(negedge clk);
        bus.instr = mk(NOP, 3'd0, 3'd0, 3'd0);

        // Asynchronous reset mid clock-low, instruction held across it
        for (int i = 0; i < 8; i++) dut.rf.regs[i] = 16'(i + 1);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) check($sformatf("async_rst_r%0d", i), 32'(dut.rf.regs[i]), 32'd0);
        bus.instr = mk(ADD, 3'd0, 3'd1, 3'd2);
        dut.rf.regs[0] = 16'd5;
        #1;
        check("rst_alu_comb", 32'(bus.alu_result), 32'd5);
        check("rst_wben_comb", 32'(bus.wb_en), 32'd1);
        @(posedge clk);
        #1;
        check("rst_no_write_r2", 32'(dut.rf.regs[2]), 32'd0);
        check("rst_clears_r0", 32'(dut.rf.regs[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dut.rf.regs[0] = 16'd5;
        push("post_rst_write", 2, 16'd5);
        @(posedge clk);
        #1;
        pop_check();
        @(negedge clk);
        bus.instr = mk(NOP, 3'd0, 3'd0, 3'd0);

        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
